// File: rtl/usb_crc16_tx_if.sv
// Byte stream bundle for the USB transmit CRC stage: upstream payload side and PHY side.
interface usb_crc16_tx_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_zlp;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;

    modport slave (
        input  in_data, in_valid, in_last, in_zlp, out_ready,
        output in_ready, out_data, out_valid, out_last
    );

    modport master (
        output in_data, in_valid, in_last, in_zlp, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/usb_crc16_tx.sv
// USB transmit byte stage: forwards payload through one output register and
// appends the inverted CRC16 (low byte first) after the last payload byte.
module usb_crc16_tx #(
    parameter int unsigned MAX_BYTES = 1024,
    parameter int unsigned CNT_W     = 11
) (
    input  logic             clk,
    input  logic             reset,
    usb_crc16_tx_if.slave    bus,
    output logic [CNT_W-1:0] byte_count,
    output logic             len_err,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, DATA, CRC_LO, CRC_HI} state_t;

    state_t           state;
    logic [15:0]      crc;
    logic [15:0]      crc_upd;
    logic             slot_free;
    logic             accept;
    logic [CNT_W-1:0] cnt_inc;

    // Reflected CRC16 (0xA001), data consumed LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c_in, input logic [7:0] d);
        logic [15:0] c;
        c = c_in;
        for (int unsigned i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ 16'hA001;
            else             c = c >> 1;
        end
        return c;
    endfunction

    assign slot_free    = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = ((state == IDLE) || (state == DATA)) && slot_free;
    assign accept       = bus.in_valid && bus.in_ready;
    // First byte of a packet always starts from the init value, whatever crc holds.
    assign crc_upd      = crc16_byte((state == IDLE) ? 16'hFFFF : crc, bus.in_data);
    assign cnt_inc      = (byte_count == '1) ? byte_count : byte_count + 1'b1;
    assign busy         = (state != IDLE) || bus.out_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            crc           <= 16'hFFFF;
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            byte_count    <= '0;
            len_err       <= 1'b0;
        end else begin
            if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
                bus.out_last  <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        bus.out_data  <= bus.in_data;
                        bus.out_valid <= 1'b1;
                        bus.out_last  <= 1'b0;
                        crc           <= crc_upd;
                        byte_count    <= CNT_W'(1);
                        len_err       <= 1'b0;
                        state         <= bus.in_last ? CRC_LO : DATA;
                    end else if (bus.in_zlp && slot_free) begin
                        crc        <= 16'hFFFF;
                        byte_count <= '0;
                        len_err    <= 1'b0;
                        state      <= CRC_LO;
                    end
                end
                DATA: begin
                    if (accept) begin
                        bus.out_data  <= bus.in_data;
                        bus.out_valid <= 1'b1;
                        bus.out_last  <= 1'b0;
                        crc           <= crc_upd;
                        byte_count    <= cnt_inc;
                        if (32'(cnt_inc) > MAX_BYTES) len_err <= 1'b1;
                        if (bus.in_last) state <= CRC_LO;
                    end
                end
                CRC_LO: begin
                    if (slot_free) begin
                        bus.out_data  <= ~crc[7:0];
                        bus.out_valid <= 1'b1;
                        bus.out_last  <= 1'b0;
                        state         <= CRC_HI;
                    end
                end
                CRC_HI: begin
                    if (slot_free) begin
                        bus.out_data  <= ~crc[15:8];
                        bus.out_valid <= 1'b1;
                        bus.out_last  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_usb_crc16_tx.sv
// Directed bench for usb_crc16_tx: default instance plus a MAX_BYTES=4 instance for length errors.
module tb_usb_crc16_tx;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [7:0] in_data;
    logic       in_valid, in_last, in_zlp, out_ready, sel;

    usb_crc16_tx_if ia ();
    usb_crc16_tx_if ib ();

    assign ia.in_data   = in_data;
    assign ib.in_data   = in_data;
    assign ia.in_valid  = in_valid && !sel;
    assign ib.in_valid  = in_valid && sel;
    assign ia.in_last   = in_last;
    assign ib.in_last   = in_last;
    assign ia.in_zlp    = in_zlp && !sel;
    assign ib.in_zlp    = in_zlp && sel;
    assign ia.out_ready = out_ready;
    assign ib.out_ready = out_ready;

    logic [10:0] bc_a;
    logic [2:0]  bc_b;
    logic        le_a, le_b, busy_a, busy_b;

    usb_crc16_tx dut_a (
        .clk(clk), .reset(reset), .bus(ia),
        .byte_count(bc_a), .len_err(le_a), .busy(busy_a)
    );

    usb_crc16_tx #(.MAX_BYTES(4), .CNT_W(3)) dut_b (
        .clk(clk), .reset(reset), .bus(ib),
        .byte_count(bc_b), .len_err(le_b), .busy(busy_b)
    );

    logic        o_valid, o_last, i_ready, o_err;
    logic [7:0]  o_data;
    logic [10:0] o_cnt;
    assign o_valid = sel ? ib.out_valid : ia.out_valid;
    assign o_last  = sel ? ib.out_last  : ia.out_last;
    assign o_data  = sel ? ib.out_data  : ia.out_data;
    assign i_ready = sel ? ib.in_ready  : ia.in_ready;
    assign o_err   = sel ? le_b : le_a;
    assign o_cnt   = sel ? {8'b0, bc_b} : bc_a;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0] pkt[$];
    bit         lst[$];
    logic [7:0] got_d[$];
    logic       got_l[$];
    logic [7:0] exp_d[$];
    logic       exp_l[$];
    int         acc_cyc[$];
    int         first_out, low_rdy, stable_bad, err_at, ncyc;

    // Independent model: MSB-first 0x8005 register on bit-reversed data, reflected at the end.
    function automatic logic [15:0] crc_model(input logic [7:0] b[$]);
        logic [15:0] r, rr;
        logic        fb;
        r = 16'hFFFF;
        foreach (b[k]) begin
            for (int i = 0; i < 8; i++) begin
                fb = r[15] ^ b[k][i];
                r  = {r[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
            end
        end
        for (int i = 0; i < 16; i++) rr[i] = r[15-i];
        return ~rr;
    endfunction

    task automatic load_seq(input logic [7:0] start, input int n);
        pkt.delete(); lst.delete();
        for (int i = 0; i < n; i++) begin
            pkt.push_back(start + 8'(i));
            lst.push_back(i == n - 1);
        end
    endtask

    task automatic add_exp(input logic [7:0] d, input logic l);
        exp_d.push_back(d);
        exp_l.push_back(l);
    endtask

    task automatic exp_payload_crc(input logic [15:0] tx);
        exp_d.delete(); exp_l.delete();
        foreach (pkt[i]) add_exp(pkt[i], 1'b0);
        add_exp(tx[7:0], 1'b0);
        add_exp(tx[15:8], 1'b1);
    endtask

    // Called just after a rising edge; drives one cycle of stimulus per loop pass.
    task automatic run(input bit zlp, input bit stall, input int nout, input int budget);
        int         sent;
        bit         held;
        logic [8:0] held_v;
        sent = 0; held = 0; held_v = '0;
        got_d.delete(); got_l.delete(); acc_cyc.delete();
        first_out = -1; low_rdy = 0; stable_bad = 0; err_at = -1; ncyc = 0;
        while (got_d.size() < nout && ncyc < budget) begin
            out_ready = stall ? (ncyc % 3 == 0) : 1'b1;
            in_zlp    = zlp && (ncyc == 0);
            if (!zlp && sent < pkt.size()) begin
                in_valid = 1'b1; in_data = pkt[sent]; in_last = lst[sent];
            end else begin
                in_valid = 1'b0; in_data = '0; in_last = 1'b0;
            end
            @(negedge clk);
            if (held && (!o_valid || {o_last, o_data} != held_v)) stable_bad++;
            held   = o_valid && !out_ready;
            held_v = {o_last, o_data};
            if (o_valid && out_ready) begin
                got_d.push_back(o_data);
                got_l.push_back(o_last);
                if (first_out < 0) first_out = ncyc;
            end
            if (!i_ready) low_rdy++;
            if (o_err && err_at < 0) err_at = sent;
            if (in_valid && i_ready) begin
                acc_cyc.push_back(ncyc);
                sent++;
            end
            @(posedge clk); #1;
            ncyc++;
        end
        in_valid = 1'b0; in_zlp = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        check("out_count", got_d.size(), nout);
    endtask

    task automatic cmp_stream(input string tag);
        int n;
        n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
        check({tag, "_len"}, got_d.size(), exp_d.size());
        for (int i = 0; i < n; i++)
            check($sformatf("%s[%0d]", tag, i), {23'b0, got_l[i], got_d[i]}, {23'b0, exp_l[i], exp_d[i]});
    endtask

    initial begin
        reset = 1'b1; sel = 1'b0; in_data = '0; in_valid = 1'b0;
        in_last = 1'b0; in_zlp = 1'b0; out_ready = 1'b1;
        #12 reset = 1'b0;
        #1;
        check("rst_in_ready", i_ready, 1);
        check("rst_out_valid", o_valid, 0);
        check("rst_out_last", o_last, 0);
        check("rst_out_data", o_data, 0);
        check("rst_byte_count", o_cnt, 0);
        check("rst_len_err", o_err, 0);
        check("rst_busy", busy_a, 0);
        @(posedge clk); #1;

        // "123456789" at full rate
        load_seq(8'h31, 9);
        exp_payload_crc(16'hB4C8);
        run(0, 0, 11, 100);
        cmp_stream("crc_check");
        check("check_byte_count", o_cnt, 9);
        check("check_first_latency", first_out, 1);
        check("check_cycles", ncyc, 12);
        check("check_busy_after", busy_a, 0);

        // Zero-length packet
        pkt.delete(); lst.delete();
        exp_d.delete(); exp_l.delete();
        add_exp(8'h00, 0); add_exp(8'h00, 1);
        run(1, 0, 2, 50);
        cmp_stream("zlp");
        check("zlp_byte_count", o_cnt, 0);
        check("zlp_ready_low", low_rdy, 2);

        // Same payload with out_ready 1 on / 2 off
        load_seq(8'h31, 9);
        exp_payload_crc(16'hB4C8);
        run(0, 1, 11, 200);
        cmp_stream("stall");
        check("stall_stable", stable_bad, 0);

        // Over-length packet on the MAX_BYTES=4 instance
        sel = 1'b1;
        load_seq(8'h01, 6);
        exp_payload_crc(crc_model(pkt));
        run(0, 0, 8, 100);
        cmp_stream("len6");
        check("len_err_set", o_err, 1);
        check("len_err_at_5th", err_at, 5);
        check("len_byte_count", o_cnt, 6);
        load_seq(8'hAA, 1);
        exp_payload_crc(crc_model(pkt));
        run(0, 0, 3, 50);
        cmp_stream("len1");
        check("len_err_cleared", o_err, 0);
        check("len1_byte_count", o_cnt, 1);
        sel = 1'b0;

        // Asynchronous reset mid-packet
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 8'h31 + 8'(i); in_last = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("pre_rst_valid", o_valid, 1);
        #2 reset = 1'b1;
        #1;
        check("async_out_valid", o_valid, 0);
        check("async_out_data", o_data, 0);
        check("async_byte_count", o_cnt, 0);
        check("async_busy", busy_a, 0);
        @(negedge clk); #2 reset = 1'b0;
        @(posedge clk); #1;
        load_seq(8'h31, 9);
        exp_payload_crc(16'hB4C8);
        run(0, 0, 11, 100);
        cmp_stream("post_rst");

        // Back-to-back single-byte packets 0x00 then 0xFF
        pkt.delete(); lst.delete();
        pkt.push_back(8'h00); lst.push_back(1);
        pkt.push_back(8'hFF); lst.push_back(1);
        exp_d.delete(); exp_l.delete();
        add_exp(8'h00, 0); add_exp(8'h40, 0); add_exp(8'hBF, 1);
        add_exp(8'hFF, 0); add_exp(8'h00, 0); add_exp(8'hFF, 1);
        run(0, 0, 6, 50);
        cmp_stream("b2b");
        check("b2b_second_accept", (acc_cyc.size() > 1) ? acc_cyc[1] : -1, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
